// File: rtl/led_cmd_controller.sv
// Command sequencer for the SPI byte front end: decodes commands, loads response
// bytes and arbitrates the shared LED/toggle-counter between SPI and a local requester.
module led_cmd_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SPI_CS,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    input  logic                  loc_req,
    output logic                  loc_ack,
    output logic                  led,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_NOP         = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] CMD_TOGGLE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CMD_READ_CNT    = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE_LED   = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] CMD_CLR_CNT     = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] CMD_READ_STATUS = DATA_WIDTH'(5);

    // Zero-extends or truncates the counter to the response byte width.
    function automatic logic [DATA_WIDTH-1:0] cnt_to_data(input logic [CNT_WIDTH-1:0] c);
        logic [DATA_WIDTH+CNT_WIDTH-1:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, c};
        return ext[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] status_byte(input logic e, input logic l);
        return {{(DATA_WIDTH-2){1'b0}}, e, l};
    endfunction

    state_t                  state, state_nxt;
    logic                    led_nxt, err_nxt, tx_load_nxt, loc_ack_nxt, spi_mod;
    logic [CNT_WIDTH-1:0]    cnt_nxt;
    logic [DATA_WIDTH-1:0]   tx_data_nxt;

    always_comb begin
        state_nxt   = state;
        led_nxt     = led;
        cnt_nxt     = cnt;
        err_nxt     = err;
        tx_data_nxt = tx_data;
        tx_load_nxt = 1'b0;
        spi_mod     = 1'b0;
        loc_ack_nxt = 1'b0;

        if (SPI_CS) begin
            state_nxt = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        CMD_NOP: ;
                        CMD_TOGGLE: begin
                            spi_mod = 1'b1;
                            led_nxt = ~led;
                            cnt_nxt = cnt + CNT_WIDTH'(1);
                        end
                        CMD_READ_CNT: begin
                            tx_data_nxt = cnt_to_data(cnt);
                            tx_load_nxt = 1'b1;
                            state_nxt   = RESP;
                        end
                        CMD_WRITE_LED: state_nxt = ARG;
                        CMD_CLR_CNT: begin
                            spi_mod = 1'b1;
                            cnt_nxt = '0;
                        end
                        CMD_READ_STATUS: begin
                            tx_data_nxt = status_byte(err, led);
                            tx_load_nxt = 1'b1;
                            err_nxt     = 1'b0;
                            state_nxt   = RESP;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
                ARG: begin
                    spi_mod   = 1'b1;
                    led_nxt   = rx_data[0];
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Local toggle takes any cycle free of SPI updates; never two grants back to back.
        if (loc_req && !spi_mod && !loc_ack) begin
            loc_ack_nxt = 1'b1;
            led_nxt     = ~led;
            cnt_nxt     = cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            led     <= 1'b1;
            cnt     <= '0;
            err     <= 1'b0;
            tx_data <= '0;
            tx_load <= 1'b0;
            loc_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            led     <= led_nxt;
            cnt     <= cnt_nxt;
            err     <= err_nxt;
            tx_data <= tx_data_nxt;
            tx_load <= tx_load_nxt;
            loc_ack <= loc_ack_nxt;
        end
    end

endmodule
